// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Defines the controller FSM states and the pipeline-bank stage indices.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        FREEZE = 2'd3
    } hz_state_t;

    localparam int unsigned ST_PC    = 0;
    localparam int unsigned ST_IFID  = 1;
    localparam int unsigned ST_IDEX  = 2;
    localparam int unsigned ST_EXMEM = 3;
    localparam int unsigned ST_MEMWB = 4;

    localparam int unsigned NSTAGE_DEF    = 5;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned MAX_STALL_DEF = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Request/response bundle between the hazard unit and the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned CNT_W  = 16
);

    logic              stall;
    logic [NSTAGE-1:0] flush;
    logic              mem_busy;
    logic [NSTAGE-1:0] stage_en;
    logic [NSTAGE-1:0] stage_clr;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              stall_err;

    modport master (
        output stall, flush, mem_busy,
        input  stage_en, stage_clr, state_o, stall_cnt, flush_cnt, stall_err
    );

    modport slave (
        input  stall, flush, mem_busy,
        output stage_en, stage_clr, state_o, stall_cnt, flush_cnt, stall_err
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Turns stall/flush/mem_busy requests into per-stage write enables and bubble clears,
// remembers flushes raised during a memory freeze and keeps stall/flush statistics.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NSTAGE    = NSTAGE_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned MAX_STALL = MAX_STALL_DEF
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL - 1);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL);

    hz_state_t         state_q,      state_d;
    logic [NSTAGE-1:0] pend_flush_q, pend_flush_d;
    logic [RUN_W-1:0]  run_len_q,    run_len_d;
    logic              stall_err_q,  stall_err_d;

    logic [NSTAGE-1:0] eff_flush;
    logic [NSTAGE-1:0] en_c;
    logic [NSTAGE-1:0] clr_c;
    logic              stall_applied;
    logic              stall_inc;
    logic              flush_inc;

    // Priority decode: freeze > flush > unmasked stall > run.
    always_comb begin
        state_d       = RUN;
        pend_flush_d  = pend_flush_q;
        run_len_d     = '0;
        stall_err_d   = stall_err_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        en_c          = '1;
        clr_c         = '0;
        eff_flush     = bus.flush | pend_flush_q;
        stall_applied = bus.stall && (state_q != FLUSH);

        if (rst) begin
            en_c  = '0;
            clr_c = '1;
        end else if (bus.mem_busy) begin
            en_c         = '0;
            state_d      = FREEZE;
            pend_flush_d = pend_flush_q | bus.flush;
        end else if (|eff_flush) begin
            clr_c        = eff_flush;
            state_d      = FLUSH;
            pend_flush_d = '0;
            flush_inc    = 1'b1;
        end else if (stall_applied) begin
            en_c[ST_PC]    = 1'b0;
            en_c[ST_IFID]  = 1'b0;
            clr_c[ST_IDEX] = 1'b1;
            state_d        = STALL;
            stall_inc      = 1'b1;
            // The stall that completes MAX_STALL consecutive cycles trips the watchdog.
            if (run_len_q >= RUN_LIM) begin
                stall_err_d = 1'b1;
                run_len_d   = RUN_SAT;
            end else begin
                run_len_d = run_len_q + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pend_flush_q <= '0;
            run_len_q    <= '0;
            stall_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
            run_len_q    <= run_len_d;
            stall_err_q  <= stall_err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .en  (stall_inc),
        .q   (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .en  (flush_inc),
        .q   (bus.flush_cnt)
    );

    assign bus.stage_en  = en_c;
    assign bus.stage_clr = clr_c;
    assign bus.state_o   = 2'(state_q);
    assign bus.stall_err = stall_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the controller rules.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned NSTAGE    = 5;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MAX_STALL = 4;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    pipeline_hazard_ctrl_if #(.NSTAGE(NSTAGE), .CNT_W(CNT_W)) hif ();

    pipeline_hazard_ctrl #(
        .NSTAGE   (NSTAGE),
        .CNT_W    (CNT_W),
        .MAX_STALL(MAX_STALL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    // Reference model: 0=RUN 1=STALL 2=FLUSH 3=FREEZE
    int         m_state;
    logic [4:0] m_pend;
    int         m_stall_cnt;
    int         m_flush_cnt;
    int         m_streak;
    bit         m_err;
    bit         m_known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check comb + registered outputs, then advance the model.
    task automatic cycle(input logic r, input logic s, input logic [4:0] f, input logic b);
        logic [4:0] e_en;
        logic [4:0] e_clr;
        logic [4:0] flush_all;
        bit         stall_ok;
        @(negedge clk);
        rst          = r;
        hif.stall    = s;
        hif.flush    = f;
        hif.mem_busy = b;
        #1;
        flush_all = f | m_pend;
        stall_ok  = s && (m_state != 2);
        if (r) begin
            e_en = 5'b00000; e_clr = 5'b11111;
        end else if (b) begin
            e_en = 5'b00000; e_clr = 5'b00000;
        end else if (flush_all != 5'b0) begin
            e_en = 5'b11111; e_clr = flush_all;
        end else if (stall_ok) begin
            e_en = 5'b11100; e_clr = 5'b00100;
        end else begin
            e_en = 5'b11111; e_clr = 5'b00000;
        end
        chk("stage_en", 32'(hif.stage_en), 32'(e_en));
        chk("stage_clr", 32'(hif.stage_clr), 32'(e_clr));
        if (m_known) begin
            chk("state_o", 32'(hif.state_o), 32'(m_state));
            chk("stall_cnt", 32'(hif.stall_cnt), 32'(m_stall_cnt));
            chk("flush_cnt", 32'(hif.flush_cnt), 32'(m_flush_cnt));
            chk("stall_err", 32'(hif.stall_err), 32'(m_err));
        end
        @(posedge clk);
        if (r) begin
            m_state = 0; m_pend = '0; m_stall_cnt = 0; m_flush_cnt = 0;
            m_streak = 0; m_err = 1'b0; m_known = 1'b1;
        end else if (b) begin
            m_state = 3; m_pend = m_pend | f; m_streak = 0;
        end else if (flush_all != 5'b0) begin
            m_state = 2; m_pend = '0; m_streak = 0;
            if (m_flush_cnt < CNT_MAX) m_flush_cnt++;
        end else if (stall_ok) begin
            m_state = 1; m_streak++;
            if (m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (m_streak >= MAX_STALL) m_err = 1'b1;
        end else begin
            m_state = 0; m_streak = 0;
        end
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        m_state = 0; m_pend = '0; m_stall_cnt = 0; m_flush_cnt = 0;
        m_streak = 0; m_err = 1'b0; m_known = 1'b0;
        rst = 1'b1; hif.stall = 1'b0; hif.flush = '0; hif.mem_busy = 1'b0;

        // Reset for two cycles, then idle
        cycle(1'b1, 1'b0, 5'b0, 1'b0);
        cycle(1'b1, 1'b0, 5'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 5'b0, 1'b0);

        // Load-use stall
        cycle(1'b0, 1'b1, 5'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'b0, 1'b0);

        // Branch flush with simultaneous stall, then a masked stall
        cycle(1'b1, 1'b0, 5'b0, 1'b0);
        cycle(1'b0, 1'b1, 5'b01110, 1'b0);
        cycle(1'b0, 1'b1, 5'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'b0, 1'b0);
        chk("branch_flush_cnt", 32'(hif.flush_cnt), 32'd1);
        chk("branch_stall_cnt", 32'(hif.stall_cnt), 32'd0);

        // Freeze with a flush captured in its first cycle
        cycle(1'b0, 1'b0, 5'b01110, 1'b1);
        cycle(1'b0, 1'b0, 5'b0, 1'b1);
        cycle(1'b0, 1'b1, 5'b0, 1'b1);
        cycle(1'b0, 1'b0, 5'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'b0, 1'b0);

        // Reset while a flush is pending drops it
        cycle(1'b0, 1'b0, 5'b10001, 1'b1);
        cycle(1'b1, 1'b0, 5'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'b0, 1'b0);

        // Watchdog: five consecutive stalls, then idle
        repeat (5) cycle(1'b0, 1'b1, 5'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 5'b0, 1'b0);
        chk("stall_err_sticky", 32'(hif.stall_err), 32'd1);

        // Stall counter saturation
        cycle(1'b1, 1'b0, 5'b0, 1'b0);
        repeat (20) begin
            cycle(1'b0, 1'b1, 5'b0, 1'b0);
            cycle(1'b0, 1'b0, 5'b0, 1'b0);
        end
        chk("stall_cnt_sat", 32'(hif.stall_cnt), 32'hF);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic       r_r;
            logic       r_s;
            logic [4:0] r_f;
            logic       r_b;
            r_r = ($urandom_range(0, 99) < 2);
            r_s = 1'($urandom_range(0, 1));
            r_f = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'b0;
            r_b = ($urandom_range(0, 9) < 2);
            cycle(r_r, r_s, r_f, r_b);
        end
        cycle(1'b0, 1'b0, 5'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
